hazard_controller: RTL and testbench
====================================

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 Parameter reg_addr_width, default 5, register-address width.
REQ-002 Parameter timeout_cycles, default 255, maximum memory-wait cycles before forced exit.
REQ-003 clk  input  1  pipeline clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 id_rs1, id_rs2  input  reg_addr_width  source registers of the instruction in Decode.
REQ-006 ex_rd  input  reg_addr_width  destination register of the instruction in Execute.
REQ-007 ex_mem_read  input  1  instruction in Execute is a load.
REQ-008 branch_taken  input  1  branch resolved taken in Memory stage.
REQ-009 mem_req, mem_ready  input  1 each  data-memory request/ready handshake.
REQ-010 stall_if  output  1  hold PC and IF/ID register.
REQ-011 stall_id  output  1  hold ID/EX register (Decode stall).
REQ-012 flush_if, flush_id, flush_ex  output  1 each  clear IF/ID, ID/EX (Decode flush), EX/MEM to NOP.
REQ-013 freeze_all  output  1  hold EX/MEM and MEM/WB registers.
REQ-014 state  output  2  current FSM state.
REQ-015 mem_timeout  output  1  sticky memory-timeout flag.
REQ-016 stall_count  output  16  saturating count of cycles with stall_if high.

Function
REQ-017 FSM states: RUN=0, LOAD_STALL=1, BRANCH_FLUSH=2, MEM_WAIT=3.
REQ-018 Hazard outputs are combinational from state and current inputs (same-cycle response); state, counters and flags are registered.
REQ-019 load_use = ex_mem_read & (ex_rd != 0) & (ex_rd == id_rs1 | ex_rd == id_rs2).
REQ-020 mem_wait = mem_req & ~mem_ready.
REQ-021 Priority in any state: mem_wait > branch_taken > load_use.
REQ-022 mem_wait: stall_if=stall_id=freeze_all=1, all flushes 0; next state MEM_WAIT; wait counter increments.
REQ-023 MEM_WAIT exits to RUN the cycle after mem_ready rises; a branch_taken held during the wait is acted on in the first non-wait cycle.
REQ-024 When the wait counter reaches timeout_cycles: mem_timeout set, freeze released that cycle, next state RUN, counter cleared.
REQ-025 branch_taken in RUN or LOAD_STALL: flush_if=flush_id=flush_ex=1 that cycle, stalls 0; next state BRANCH_FLUSH.
REQ-026 BRANCH_FLUSH lasts exactly one cycle, ignores branch_taken and load_use (wrong-path), outputs all 0 unless mem_wait; then RUN.
REQ-027 load_use in RUN: stall_if=1, flush_id=1 (bubble into ID/EX), stall_id=0; next state LOAD_STALL.
REQ-028 LOAD_STALL lasts one cycle; a fresh load_use there re-stalls and stays in LOAD_STALL, else RUN.
REQ-029 No hazard: all control outputs 0, state RUN.
REQ-030 stall_count increments when stall_if=1, saturates at 16'hFFFF, never wraps.
REQ-031 mem_timeout cleared only by reset.

Reset
REQ-032 reset asserted: state=RUN, wait counter=0, stall_count=0, mem_timeout=0 immediately, independent of clk.
REQ-033 Combinational outputs during reset: stall_if, stall_id, all flushes and freeze_all forced 0.
REQ-034 Reset mid-wait or mid-flush abandons the sequence; first post-reset cycle evaluates from RUN.

Structure
REQ-035 State encodings and reset defaults for counters reside in a shared pipeline package used by all stages.
REQ-036 Single sub-module hazard_detect: combinational load_use comparator, reusable for forwarding logic.

Verification
REQ-037 ex_mem_read=1, ex_rd=5, id_rs1=5 -> stall_if=1, flush_id=1 for one cycle, state RUN->LOAD_STALL->RUN, stall_count=1.
REQ-038 ex_mem_read=1, ex_rd=0, id_rs1=0 -> no stall, state stays RUN.
REQ-039 branch_taken=1 with load_use=1 -> flush_if/id/ex=1, stall_if=0, next state BRANCH_FLUSH; branch_taken held next cycle -> no flush.
REQ-040 mem_req=1, mem_ready=0 for 4 cycles with branch_taken=1 -> freeze_all=1 for 4 cycles, flushes 0, then flush pulse after mem_ready, stall_count=4.
REQ-041 timeout_cycles=3, mem_ready held 0 -> mem_timeout=1 after 3 wait cycles, state RUN, flag persists until reset.
REQ-042 reset asserted asynchronously in MEM_WAIT with stall_count=10 -> state=0, stall_count=0, all outputs 0 before next clk edge.

Source files
------------

// File: rtl/hazard_controller_pkg.sv
// Shared pipeline definitions: hazard FSM encoding and counter reset values.
package hazard_controller_pkg;

  typedef enum logic [1:0] {
    RUN          = 2'd0,
    LOAD_STALL   = 2'd1,
    BRANCH_FLUSH = 2'd2,
    MEM_WAIT     = 2'd3
  } hz_state_e;

  localparam int                   STALL_CNT_W   = 16;
  localparam logic [STALL_CNT_W-1:0] STALL_CNT_RST = '0;
  localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = '1;

  // Saturating increment: a performance counter that wraps would lie.
  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (v == STALL_CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/hazard_controller_hazard_detect.sv
// Load-use comparator: Decode sources against a pending load destination.
// Kept standalone so the forwarding unit can reuse the same compare.
module hazard_detect #(
  parameter int reg_addr_width = 5
) (
  input  logic                      ex_mem_read,
  input  logic [reg_addr_width-1:0] ex_rd,
  input  logic [reg_addr_width-1:0] id_rs1,
  input  logic [reg_addr_width-1:0] id_rs2,
  output logic                      load_use
);

  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use stall, taken-branch flush, memory-wait
// freeze with timeout, plus a saturating stall-cycle counter.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int reg_addr_width = 5,
  parameter int timeout_cycles = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [reg_addr_width-1:0] id_rs1,
  input  logic [reg_addr_width-1:0] id_rs2,
  input  logic [reg_addr_width-1:0] ex_rd,
  input  logic                      ex_mem_read,
  input  logic                      branch_taken,
  input  logic                      mem_req,
  input  logic                      mem_ready,
  output logic                      stall_if,
  output logic                      stall_id,
  output logic                      flush_if,
  output logic                      flush_id,
  output logic                      flush_ex,
  output logic                      freeze_all,
  output logic [1:0]                state,
  output logic                      mem_timeout,
  output logic [15:0]               stall_count
);

  localparam int              WCW      = (timeout_cycles < 2) ? 1 : $clog2(timeout_cycles + 1);
  localparam logic [WCW-1:0]  WAIT_MAX = WCW'(timeout_cycles);

  hz_state_e      st, nst;
  logic [WCW-1:0] wait_cnt;
  logic           load_use, mem_wait, timeout_hit;

  hazard_detect #(.reg_addr_width(reg_addr_width)) u_detect (
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .load_use    (load_use)
  );

  assign mem_wait    = mem_req & ~mem_ready;
  // The wait has run its budget: force an exit instead of freezing again.
  assign timeout_hit = mem_wait & (wait_cnt == WAIT_MAX);
  assign state       = st;

  // State register; reset abandons any in-flight wait or flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) st <= RUN;
    else       st <= nst;
  end

  // Next state: mem_wait beats branch beats load_use; BRANCH_FLUSH is wrong-path.
  always_comb begin
    nst = RUN;
    if (mem_wait)                nst = timeout_hit ? RUN : MEM_WAIT;
    else if (st == BRANCH_FLUSH) nst = RUN;
    else if (branch_taken)       nst = BRANCH_FLUSH;
    else if (load_use)           nst = LOAD_STALL;
  end

  // Same-cycle control outputs, held low while reset is asserted.
  always_comb begin
    stall_if   = 1'b0;
    stall_id   = 1'b0;
    flush_if   = 1'b0;
    flush_id   = 1'b0;
    flush_ex   = 1'b0;
    freeze_all = 1'b0;
    if (!reset) begin
      if (mem_wait) begin
        if (!timeout_hit) begin
          stall_if   = 1'b1;
          stall_id   = 1'b1;
          freeze_all = 1'b1;
        end
      end else if (st != BRANCH_FLUSH) begin
        if (branch_taken) begin
          flush_if = 1'b1;
          flush_id = 1'b1;
          flush_ex = 1'b1;
        end else if (load_use) begin
          // Hold fetch/decode and push a bubble into ID/EX.
          stall_if = 1'b1;
          flush_id = 1'b1;
        end
      end
    end
  end

  // Wait counter, sticky timeout flag and saturating stall counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
      stall_count <= STALL_CNT_RST;
    end else begin
      wait_cnt <= (mem_wait && !timeout_hit) ? wait_cnt + 1'b1 : '0;
      if (timeout_hit) mem_timeout <= 1'b1;
      if (stall_if)    stall_count <= sat_inc(stall_count);
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Bench: two controllers (default timeout and timeout of 3) share stimulus and
// are checked every cycle against a rule-level model, plus directed scenarios.
module tb_hazard_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       ex_mem_read = 1'b0, branch_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;

  logic        a_sif, a_sid, a_fif, a_fid, a_fex, a_frz, a_to;
  logic [1:0]  a_st;
  logic [15:0] a_cnt;
  logic        b_sif, b_sid, b_fif, b_fid, b_fex, b_frz, b_to;
  logic [1:0]  b_st;
  logic [15:0] b_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hazard_controller dut_a (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .branch_taken(branch_taken), .mem_req(mem_req),
    .mem_ready(mem_ready), .stall_if(a_sif), .stall_id(a_sid), .flush_if(a_fif),
    .flush_id(a_fid), .flush_ex(a_fex), .freeze_all(a_frz), .state(a_st),
    .mem_timeout(a_to), .stall_count(a_cnt)
  );

  hazard_controller #(.timeout_cycles(3)) dut_b (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .branch_taken(branch_taken), .mem_req(mem_req),
    .mem_ready(mem_ready), .stall_if(b_sif), .stall_id(b_sid), .flush_if(b_fif),
    .flush_id(b_fid), .flush_ex(b_fex), .freeze_all(b_frz), .state(b_st),
    .mem_timeout(b_to), .stall_count(b_cnt)
  );

  // Reference model: plain integers, one record per DUT.
  typedef struct {
    int st;    // 0 run, 1 load stall, 2 branch flush, 3 mem wait
    int wcnt;
    int scnt;
    bit to;
  } mdl_t;

  mdl_t m[2];
  int   tmo[2] = '{255, 3};

  // Expected outputs as {stall_if, stall_id, flush_if, flush_id, flush_ex, freeze_all}.
  function automatic void eval(input mdl_t s, input int tmax, output bit [5:0] o, output int ns);
    bit lu, mw;
    lu = ex_mem_read && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
    mw = mem_req && !mem_ready;
    o  = 6'b000000;
    ns = 0;
    if (mw) begin
      if (s.wcnt == tmax) ns = 0;
      else begin o = 6'b110001; ns = 3; end
    end else if (s.st == 2) ns = 0;
    else if (branch_taken) begin o = 6'b001110; ns = 2; end
    else if (lu) begin o = 6'b100100; ns = 1; end
    if (reset) o = 6'b000000;
  endfunction

  function automatic mdl_t advance(input mdl_t s, input int tmax);
    bit [5:0] o; int ns; mdl_t r; bit mw;
    eval(s, tmax, o, ns);
    mw = mem_req && !mem_ready;
    r.st   = ns;
    r.wcnt = (mw && s.wcnt != tmax) ? s.wcnt + 1 : 0;
    r.to   = s.to | (mw && s.wcnt == tmax);
    r.scnt = (o[5] && s.scnt < 65535) ? s.scnt + 1 : s.scnt;
    return r;
  endfunction

  function automatic mdl_t reset_mdl();
    mdl_t r;
    r.st = 0; r.wcnt = 0; r.scnt = 0; r.to = 1'b0;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    bit [5:0] eo; int ns;
    for (int i = 0; i < 2; i++) begin
      eval(m[i], tmo[i], eo, ns);
      if (i == 0) begin
        chk($sformatf("%s[a]/out", tag), {a_sif, a_sid, a_fif, a_fid, a_fex, a_frz}, eo);
        chk($sformatf("%s[a]/state", tag), a_st, m[0].st);
        chk($sformatf("%s[a]/cnt", tag), a_cnt, m[0].scnt);
        chk($sformatf("%s[a]/to", tag), a_to, m[0].to);
      end else begin
        chk($sformatf("%s[b]/out", tag), {b_sif, b_sid, b_fif, b_fid, b_fex, b_frz}, eo);
        chk($sformatf("%s[b]/state", tag), b_st, m[1].st);
        chk($sformatf("%s[b]/cnt", tag), b_cnt, m[1].scnt);
        chk($sformatf("%s[b]/to", tag), b_to, m[1].to);
      end
    end
  endtask

  // One clock: check mid-cycle, then advance the model on the rising edge.
  task automatic step(input string tag);
    @(negedge clk);
    check_all(tag);
    @(posedge clk);
    for (int i = 0; i < 2; i++) m[i] = advance(m[i], tmo[i]);
    #1;
  endtask

  task automatic idle();
    ex_mem_read = 0; branch_taken = 0; mem_req = 0; mem_ready = 0;
    ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
  endtask

  // Asynchronous reset mid-cycle, checked before any clock edge arrives.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) m[i] = reset_mdl();
    check_all(tag);
    idle();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset("reset");

    // Load-use on rs1: one stall cycle, then back to RUN.
    ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_rs2 = 9;
    step("lu_stall");
    idle();
    step("lu_release");
    step("lu_run");
    chk("lu_cnt", a_cnt, 32'd1);

    // Load to x0 is never a hazard.
    ex_mem_read = 1; ex_rd = 0; id_rs1 = 0;
    step("x0_load");
    step("x0_load2");
    idle();

    // Branch beats load-use; held branch in BRANCH_FLUSH is ignored.
    branch_taken = 1; ex_mem_read = 1; ex_rd = 7; id_rs2 = 7;
    step("br_flush");
    step("br_wrongpath");
    idle();
    step("br_done");

    // Four wait cycles with a pending branch, then ready -> flush.
    do_reset("reset_mw");
    mem_req = 1; mem_ready = 0; branch_taken = 1;
    for (int k = 0; k < 4; k++) step($sformatf("mw%0d", k));
    mem_ready = 1;
    step("mw_ready_flush");
    chk("mw_cnt", a_cnt, 32'd4);
    mem_req = 0; branch_taken = 0;
    step("mw_after");

    // Timeout on the short-timeout instance; flag must stay set.
    do_reset("reset_to");
    mem_req = 1; mem_ready = 0;
    for (int k = 0; k < 4; k++) step($sformatf("to%0d", k));
    chk("to_flag", b_to, 32'd1);
    chk("to_state", b_st, 32'd0);
    idle();
    for (int k = 0; k < 3; k++) step($sformatf("to_hold%0d", k));
    chk("to_sticky", b_to, 32'd1);

    // Reset in the middle of a long wait with a populated stall counter.
    do_reset("reset_pre");
    mem_req = 1; mem_ready = 0;
    for (int k = 0; k < 10; k++) step($sformatf("pre%0d", k));
    chk("pre_cnt", a_cnt, 32'd10);
    chk("pre_state", a_st, 32'd3);
    do_reset("async_reset");

    // Random traffic with a small register space to provoke collisions.
    for (int k = 0; k < 400; k++) begin
      ex_mem_read  = ($urandom_range(0, 1) == 1);
      ex_rd        = 5'($urandom_range(0, 3));
      id_rs1       = 5'($urandom_range(0, 3));
      id_rs2       = 5'($urandom_range(0, 3));
      branch_taken = ($urandom_range(0, 4) == 0);
      mem_req      = ($urandom_range(0, 3) == 0);
      mem_ready    = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 79) == 0) do_reset("rnd_reset");
      else step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
